// File: rtl/wash_pkg.sv
// Shared types and constants for the washing-machine programme controller.
// State, sub-state, actuator and display encodings live here so decode helpers stay in one place.
package wash_pkg;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        FILL        = 4'd1,
        WASH        = 4'd2,
        DRAIN       = 4'd3,
        RFILL       = 4'd4,
        RINSE       = 4'd5,
        RDRAIN      = 4'd6,
        SPIN        = 4'd7,
        DONE        = 4'd8,
        ABORT_DRAIN = 4'd9
    } state_e;

    typedef enum logic {
        ARM  = 1'b0,
        WAIT = 1'b1
    } sub_e;

    localparam logic [1:0] MOTOR_OFF     = 2'b00;
    localparam logic [1:0] MOTOR_AGITATE = 2'b01;
    localparam logic [1:0] MOTOR_SPIN    = 2'b10;

    localparam logic [1:0] MODE_LIGHT      = 2'd0;
    localparam logic [1:0] MODE_NORMAL     = 2'd1;
    localparam logic [1:0] MODE_HEAVY      = 2'd2;
    localparam logic [1:0] MODE_DRAIN_SPIN = 2'd3;

    localparam logic [2:0] PH_IDLE    = 3'd0;
    localparam logic [2:0] PH_FILL    = 3'd1;
    localparam logic [2:0] PH_AGITATE = 3'd2;
    localparam logic [2:0] PH_DRAIN   = 3'd3;
    localparam logic [2:0] PH_SPIN    = 3'd4;
    localparam logic [2:0] PH_DONE    = 3'd5;
    localparam logic [2:0] PH_ABORT   = 3'd6;

    function automatic logic [2:0] phase_code(state_e s);
        case (s)
            FILL, RFILL:   return PH_FILL;
            WASH, RINSE:   return PH_AGITATE;
            DRAIN, RDRAIN: return PH_DRAIN;
            SPIN:          return PH_SPIN;
            DONE:          return PH_DONE;
            ABORT_DRAIN:   return PH_ABORT;
            default:       return PH_IDLE;
        endcase
    endfunction

    // Every state that arms the timer on entry.
    function automatic logic is_timed(state_e s);
        return !(s == IDLE || s == DONE);
    endfunction

endpackage

// File: rtl/dffrs.sv
// Generic async active-low reset flop bank used for all state in this block.
module dffrs #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RST_VAL;
        else        q <= d;
    end

endmodule

// File: rtl/wash_duration.sv
// Combinational duration lookup: phase state plus latched mode to timer count.
module wash_duration
    import wash_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] T_FILL   = 16'd200,
    parameter logic [WIDTH-1:0] T_WASH_L = 16'd600,
    parameter logic [WIDTH-1:0] T_WASH_N = 16'd900,
    parameter logic [WIDTH-1:0] T_WASH_H = 16'd1200,
    parameter logic [WIDTH-1:0] T_DRAIN  = 16'd150,
    parameter logic [WIDTH-1:0] T_RINSE  = 16'd400,
    parameter logic [WIDTH-1:0] T_SPIN   = 16'd500
) (
    input  logic [3:0]       state,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] dur
);

    always_comb begin
        dur = '0;
        case (state_e'(state))
            FILL, RFILL:                dur = T_FILL;
            WASH: begin
                case (mode)
                    MODE_NORMAL: dur = T_WASH_N;
                    MODE_HEAVY:  dur = T_WASH_H;
                    default:     dur = T_WASH_L;
                endcase
            end
            DRAIN, RDRAIN, ABORT_DRAIN: dur = T_DRAIN;
            RINSE:                      dur = T_RINSE;
            SPIN:                       dur = T_SPIN;
            default:                    dur = '0;
        endcase
    end

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine programme controller: Moore FSM that arms the countdown timer
// on each phase entry and advances on its expiry pulse. All outputs are registered.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] T_FILL   = 16'd200,
    parameter logic [WIDTH-1:0] T_WASH_L = 16'd600,
    parameter logic [WIDTH-1:0] T_WASH_N = 16'd900,
    parameter logic [WIDTH-1:0] T_WASH_H = 16'd1200,
    parameter logic [WIDTH-1:0] T_DRAIN  = 16'd150,
    parameter logic [WIDTH-1:0] T_RINSE  = 16'd400,
    parameter logic [WIDTH-1:0] T_SPIN   = 16'd500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic             timer_irq,
    output logic             timer_load,
    output logic [WIDTH-1:0] timer_set,
    output logic             valve,
    output logic [1:0]       motor,
    output logic             drain_pump,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             done
);

    localparam int OW = WIDTH + 10;

    logic [3:0] state_raw;
    logic       sub_raw;
    state_e     state_q, state_d;
    sub_e       sub_q, sub_d;
    logic [1:0] mode_q, mode_d;
    logic [1:0] rcnt_q, rcnt_d;

    assign state_q = state_e'(state_raw);
    assign sub_q   = sub_e'(sub_raw);

    dffrs #(.W(4)) u_state (.clk(clk), .rst_n(rst_n), .d(state_d), .q(state_raw));
    dffrs #(.W(1)) u_sub   (.clk(clk), .rst_n(rst_n), .d(sub_d),   .q(sub_raw));
    dffrs #(.W(2)) u_mode  (.clk(clk), .rst_n(rst_n), .d(mode_d),  .q(mode_q));
    dffrs #(.W(2)) u_rcnt  (.clk(clk), .rst_n(rst_n), .d(rcnt_d),  .q(rcnt_q));

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        mode_d  = mode_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    state_d = (mode == MODE_DRAIN_SPIN) ? DRAIN : FILL;
                    sub_d   = ARM;
                end
            end
            DONE: state_d = IDLE;
            ABORT_DRAIN: begin
                if (sub_q == ARM)   sub_d   = WAIT;
                else if (timer_irq) state_d = IDLE;
            end
            default: begin
                // abort outranks a coincident expiry
                if (abort) begin
                    state_d = ABORT_DRAIN;
                    sub_d   = ARM;
                end else if (sub_q == ARM) begin
                    sub_d = WAIT;
                end else if (timer_irq) begin
                    sub_d = ARM;
                    case (state_q)
                        FILL:  state_d = WASH;
                        WASH:  state_d = DRAIN;
                        DRAIN: begin
                            if (mode_q == MODE_DRAIN_SPIN) begin
                                state_d = SPIN;
                            end else begin
                                rcnt_d  = mode_q + 2'd1;
                                state_d = RFILL;
                            end
                        end
                        RFILL: state_d = RINSE;
                        RINSE: state_d = RDRAIN;
                        RDRAIN: begin
                            rcnt_d  = rcnt_q - 2'd1;
                            state_d = (rcnt_q == 2'd1) ? SPIN : RFILL;
                        end
                        SPIN:    state_d = DONE;
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state_q.
    logic [WIDTH-1:0] dur;
    logic             load_d;
    logic [1:0]       motor_d;
    logic [OW-1:0]    out_d, out_q;

    wash_duration #(
        .WIDTH(WIDTH), .T_FILL(T_FILL), .T_WASH_L(T_WASH_L), .T_WASH_N(T_WASH_N),
        .T_WASH_H(T_WASH_H), .T_DRAIN(T_DRAIN), .T_RINSE(T_RINSE), .T_SPIN(T_SPIN)
    ) u_dur (
        .state(state_d),
        .mode (mode_d),
        .dur  (dur)
    );

    always_comb begin
        load_d = is_timed(state_d) && (sub_d == ARM);
        case (state_d)
            WASH, RINSE: motor_d = MOTOR_AGITATE;
            SPIN:        motor_d = MOTOR_SPIN;
            default:     motor_d = MOTOR_OFF;
        endcase
        out_d = {load_d,
                 load_d ? dur : {WIDTH{1'b0}},
                 (state_d == FILL || state_d == RFILL),
                 motor_d,
                 (state_d == DRAIN || state_d == RDRAIN || state_d == SPIN || state_d == ABORT_DRAIN),
                 phase_code(state_d),
                 is_timed(state_d),
                 (state_d == DONE)};
    end

    dffrs #(.W(OW)) u_out (.clk(clk), .rst_n(rst_n), .d(out_d), .q(out_q));

    assign {timer_load, timer_set, valve, motor, drain_pump, phase, busy, done} = out_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: small timer model, a phase-list reference model,
// directed programme runs with literal expectations, then randomized traffic.
module tb_wash_sequencer;

    localparam int TF = 3, TWL = 5, TWN = 7, TWH = 9, TD = 2, TR = 4, TS = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, force_irq = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        timer_irq, t_irq;
    logic        timer_load, valve, drain_pump, busy, done;
    logic [15:0] timer_set;
    logic [1:0]  motor;
    logic [2:0]  phase;

    always #5 clk = ~clk;

    wash_sequencer #(
        .WIDTH(16), .T_FILL(16'(TF)), .T_WASH_L(16'(TWL)), .T_WASH_N(16'(TWN)),
        .T_WASH_H(16'(TWH)), .T_DRAIN(16'(TD)), .T_RINSE(16'(TR)), .T_SPIN(16'(TS))
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .timer_irq(timer_irq), .timer_load(timer_load), .timer_set(timer_set),
        .valve(valve), .motor(motor), .drain_pump(drain_pump), .phase(phase),
        .busy(busy), .done(done)
    );

    // Countdown timer: irq one cycle when count reaches 0; fires once after reset.
    logic [15:0] t_cnt;
    logic        t_pend;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_cnt  <= '0;
            t_pend <= 1'b1;
        end else if (timer_load) begin
            t_cnt  <= timer_set;
            t_pend <= 1'b1;
        end else if (t_pend) begin
            if (t_cnt == 0) t_pend <= 1'b0;
            else            t_cnt  <= t_cnt - 16'd1;
        end
    end
    assign t_irq     = t_pend && (t_cnt == 0);
    assign timer_irq = t_irq | force_irq;

    int checks = 0, failures = 0;
    int cyc = 0;

    // Reference model: ms 0 idle, 1 running programme, 2 done cycle, 3 abort drain.
    int ms = 0, k = 0, cur = 0;
    int q_code[$], q_dur[$], q_valve[$], q_motor[$], q_pump[$];

    // Observation logs for the directed runs.
    int ld_set[$], ld_ph[$];
    int valve_cnt = 0, done_cyc = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int code, input int dur, input int v, input int m, input int p);
        q_code.push_back(code); q_dur.push_back(dur);
        q_valve.push_back(v); q_motor.push_back(m); q_pump.push_back(p);
    endtask

    task automatic build(input int md);
        q_code.delete(); q_dur.delete(); q_valve.delete(); q_motor.delete(); q_pump.delete();
        if (md != 3) begin
            push(1, TF, 1, 0, 0);
            push(2, (md == 0) ? TWL : (md == 1) ? TWN : TWH, 0, 1, 0);
            push(3, TD, 0, 0, 1);
            for (int r = 0; r <= md; r++) begin
                push(1, TF, 1, 0, 0);
                push(2, TR, 0, 1, 0);
                push(3, TD, 0, 0, 1);
            end
        end else begin
            push(3, TD, 0, 0, 1);
        end
        push(4, TS, 0, 2, 1);
    endtask

    task automatic model_step(input logic st, input logic ab, input int md);
        case (ms)
            0: if (st) begin build(md); ms = 1; k = 0; cur = 0; end
            1: begin
                if (ab) begin
                    ms = 3; k = 0;
                end else begin
                    k++;
                    if (k == q_dur[cur] + 2) begin
                        k = 0; cur++;
                        if (cur == q_code.size()) ms = 2;
                    end
                end
            end
            2: ms = 0;
            default: begin
                k++;
                if (k == TD + 2) ms = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        int e_load = 0, e_set = 0, e_valve = 0, e_motor = 0, e_pump = 0;
        int e_phase = 0, e_busy = 0, e_done = 0;
        case (ms)
            1: begin
                e_phase = q_code[cur]; e_valve = q_valve[cur];
                e_motor = q_motor[cur]; e_pump = q_pump[cur]; e_busy = 1;
                if (k == 0) begin e_load = 1; e_set = q_dur[cur]; end
            end
            2: begin e_phase = 5; e_done = 1; end
            3: begin
                e_phase = 6; e_pump = 1; e_busy = 1;
                if (k == 0) begin e_load = 1; e_set = TD; end
            end
            default: ;
        endcase
        chk("timer_load", int'(timer_load), e_load);
        chk("timer_set",  int'(timer_set),  e_set);
        chk("valve",      int'(valve),      e_valve);
        chk("motor",      int'(motor),      e_motor);
        chk("drain_pump", int'(drain_pump), e_pump);
        chk("phase",      int'(phase),      e_phase);
        chk("busy",       int'(busy),       e_busy);
        chk("done",       int'(done),       e_done);
    endtask

    // Drive inputs for cycle cyc, step the model, then check the outputs of cycle cyc+1.
    task automatic cycle(input logic st, input logic ab, input int md, input logic fi);
        start = st; abort = ab; mode = 2'(md); force_irq = fi;
        model_step(st, ab, md);
        @(negedge clk);
        cyc++;
        compare_all();
        if (timer_load) begin ld_set.push_back(int'(timer_set)); ld_ph.push_back(int'(phase)); end
        if (valve) valve_cnt++;
        if (done && done_cyc < 0) done_cyc = cyc;
    endtask

    task automatic clear_logs();
        ld_set.delete(); ld_ph.delete(); valve_cnt = 0; done_cyc = -1; cyc = 0;
    endtask

    task automatic reset_pulse();
        start = 0; abort = 0; force_irq = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_motor", int'(motor), 0);
        chk("rst_pump",  int'(drain_pump), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_load",  int'(timer_load), 0);
        #1;
        rst_n = 1'b1;
        ms = 0; k = 0;
    endtask

    // Run one programme from start to done; stray start injected at cycle stray_at.
    task automatic run_prog(input int md, input int stray_at);
        clear_logs();
        cycle(1, 0, md, 0);
        while (done_cyc < 0 && cyc < 200) cycle(cyc == stray_at, 0, 3, 0);
        if (done_cyc < 0) chk("done_timeout", 0, 1);
        cycle(0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        @(negedge clk);
        compare_all();   // post-reset timer irq lands here and must be ignored

        // Mode 0 with a stray start during RINSE (cycle 24).
        run_prog(0, 24);
        chk("m0_done_cyc", done_cyc, 40);
        chk("m0_nloads", ld_set.size(), 7);
        if (ld_set.size() == 7) begin
            chk("m0_set0", ld_set[0], 3); chk("m0_set1", ld_set[1], 5);
            chk("m0_set2", ld_set[2], 2); chk("m0_set3", ld_set[3], 3);
            chk("m0_set4", ld_set[4], 4); chk("m0_set5", ld_set[5], 2);
            chk("m0_set6", ld_set[6], 6);
        end

        // Abort and stray irq while idle.
        repeat (3) cycle(0, 1, 0, 1);
        chk("idle_abort_phase", int'(phase), 0);

        run_prog(3, -1);
        chk("m3_done_cyc", done_cyc, 13);
        chk("m3_valve", valve_cnt, 0);

        run_prog(2, -1);
        chk("m2_done_cyc", done_cyc, 74);
        chk("m2_nloads", ld_set.size(), 13);
        if (ld_set.size() > 1) chk("m2_wash_set", ld_set[1], 9);
        chk("m2_fills", int'(ld_ph.size() > 0 ? ld_ph.sum() with (int'(item == 1)) : 0), 4);

        // Abort in the 3rd WASH cycle together with a forced irq.
        clear_logs();
        cycle(1, 0, 1, 0);
        while (cyc < 8) cycle(0, 0, 0, 0);
        chk("ab_pre_phase", int'(phase), 2);
        cycle(0, 1, 0, 1);
        chk("ab_phase", int'(phase), 6);
        chk("ab_load", int'(timer_load), 1);
        chk("ab_set", int'(timer_set), 2);
        chk("ab_pump", int'(drain_pump), 1);
        chk("ab_motor", int'(motor), 0);
        while (cyc < 13) cycle(0, 0, 0, 0);
        chk("ab_idle_phase", int'(phase), 0);
        chk("ab_idle_busy", int'(busy), 0);
        chk("ab_no_done", done_cyc, -1);

        // Reset during SPIN.
        clear_logs();
        cycle(1, 0, 0, 0);
        while (cyc < 34) cycle(0, 0, 0, 0);
        chk("spin_motor", int'(motor), 2);
        chk("spin_pump", int'(drain_pump), 1);
        reset_pulse();
        repeat (5) cycle(0, 0, 0, 0);
        chk("post_rst_phase", int'(phase), 0);

        // Randomized traffic; forced irqs only where the controller must ignore them.
        for (int i = 0; i < 4000; i++) begin
            logic st, ab, fi;
            int   md;
            if ($urandom_range(0, 599) == 0) begin
                reset_pulse();
                continue;
            end
            st = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 39) == 0);
            md = int'($urandom_range(0, 3));
            fi = 1'b0;
            if (ms == 0 || ms == 2 || k == 0 || (ms == 1 && ab)) fi = 1'($urandom_range(0, 1));
            cycle(st, ab, md, fi);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
